// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register feeding the ALU: captures decode fields, resolves
// EX/MEM and MEM/WB forwarding per operand, and raises a one-cycle load-use hold.

module id_ex_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] data
);
    logic hit_exmem;
    logic hit_memwb;

    // Register 0 is hard-wired zero, so a write "to" it is never forwarded.
    assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src);
    assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src);

    always_comb begin
        data = reg_data;
        if (hit_exmem)      data = exmem_result;
        else if (hit_memwb) data = memwb_result;
    end
endmodule

module id_ex_forward_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic [3:0]        id_ex_cmd,
    input  logic [1:0]        id_alu_op,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_input1,
    output logic [DATA_W-1:0] ex_input2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [3:0]        ex_cmd,
    output logic [1:0]        ex_alu_op,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              load_use_stall
);
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic [3:0]        cmd;
        logic [1:0]        alu_op;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } stage_t;

    stage_t stage_q;
    stage_t id_fields;

    logic [1:0][REG_W-1:0]  fwd_src;
    logic [1:0][DATA_W-1:0] fwd_reg_data;
    logic [1:0][DATA_W-1:0] fwd_data;

    always_comb begin
        id_fields           = '0;
        id_fields.valid     = id_valid;
        id_fields.reg_write = id_reg_write;
        id_fields.mem_read  = id_mem_read;
        id_fields.mem_write = id_mem_write;
        id_fields.alu_src   = id_alu_src;
        id_fields.cmd       = id_ex_cmd;
        id_fields.alu_op    = id_alu_op;
        id_fields.rd        = id_rd;
        id_fields.rs        = id_rs;
        id_fields.rt        = id_rt;
        id_fields.rs_data   = id_rs_data;
        id_fields.rt_data   = id_rt_data;
        id_fields.imm       = id_imm;
    end

    // rt only counts as a hazard source when it is actually read: as the
    // second ALU operand or as store data.
    always_comb begin
        load_use_stall = 1'b0;
        if (!flush_in && stage_q.valid && stage_q.mem_read && (stage_q.rd != '0) && id_valid)
            load_use_stall = (stage_q.rd == id_rs) ||
                             ((stage_q.rd == id_rt) && (!id_alu_src || id_mem_write));
    end

    always_ff @(posedge clk) begin
        if (reset)               stage_q <= '0;
        else if (flush_in)       stage_q <= '0;
        else if (stall_in)       stage_q <= stage_q;
        else if (load_use_stall) stage_q <= '0;
        else                     stage_q <= id_fields;
    end

    assign fwd_src[0]      = stage_q.rs;
    assign fwd_src[1]      = stage_q.rt;
    assign fwd_reg_data[0] = stage_q.rs_data;
    assign fwd_reg_data[1] = stage_q.rt_data;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fwd
            id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mux (
                .src             (fwd_src[g]),
                .reg_data        (fwd_reg_data[g]),
                .exmem_reg_write (exmem_reg_write),
                .exmem_rd        (exmem_rd),
                .exmem_result    (exmem_result),
                .memwb_reg_write (memwb_reg_write),
                .memwb_rd        (memwb_rd),
                .memwb_result    (memwb_result),
                .data            (fwd_data[g])
            );
        end
    endgenerate

    assign ex_valid      = stage_q.valid;
    assign ex_input1     = fwd_data[0];
    assign ex_input2     = stage_q.alu_src ? stage_q.imm : fwd_data[1];
    assign ex_store_data = fwd_data[1];
    assign ex_cmd        = stage_q.cmd;
    assign ex_alu_op     = stage_q.alu_op;
    assign ex_rd         = stage_q.rd;
    assign ex_reg_write  = stage_q.reg_write;
    assign ex_mem_read   = stage_q.mem_read;
    assign ex_mem_write  = stage_q.mem_write;
endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Directed bench for id_ex_forward_stage: capture, forwarding priority,
// load-use bubble, immediate path, stall/flush and reset behaviour.

module tb_id_ex_forward_stage;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic              clk = 1'b0;
    logic              reset, stall_in, flush_in, id_valid;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic              id_alu_src;
    logic [3:0]        id_ex_cmd;
    logic [1:0]        id_alu_op;
    logic              id_reg_write, id_mem_read, id_mem_write;
    logic              exmem_reg_write, memwb_reg_write;
    logic [REG_W-1:0]  exmem_rd, memwb_rd;
    logic [DATA_W-1:0] exmem_result, memwb_result;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_input1, ex_input2, ex_store_data;
    logic [3:0]        ex_cmd;
    logic [1:0]        ex_alu_op;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write;
    logic              load_use_stall;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_forward_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_ex_cmd(id_ex_cmd), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_input1(ex_input1), .ex_input2(ex_input2),
        .ex_store_data(ex_store_data), .ex_cmd(ex_cmd), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_stall(load_use_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic src, input logic [3:0] cmd,
                          input logic [1:0] op, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_src = src;
        id_ex_cmd = cmd; id_alu_op = op; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic test_reset();
        reset = 1; stall_in = 0; flush_in = 0;
        set_id(1, 1, 2, 3, 32'd5, 32'd6, 32'd7, 0, 4'd9, 2'd1, 1, 1, 0);
        clear_fwd();
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0d want 0", ex_valid); end
        n_cmp++; if (ex_reg_write !== 1'b0) begin n_bad++; $display("FAIL reset_reg_write got %0d want 0", ex_reg_write); end
        n_cmp++; if (ex_cmd !== 4'd0) begin n_bad++; $display("FAIL reset_cmd got %0d want 0", ex_cmd); end
        n_cmp++; if (ex_input1 !== 32'd0) begin n_bad++; $display("FAIL reset_input1 got %0h want 0", ex_input1); end
        n_cmp++; if (ex_input2 !== 32'd0 || ex_store_data !== 32'd0) begin n_bad++; $display("FAIL reset_input2_store got %0h/%0h want 0/0", ex_input2, ex_store_data); end
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL reset_lus got %0d want 0", load_use_stall); end
        reset = 0;
    endtask

    task automatic test_capture();
        set_id(1, 1, 2, 3, 32'd88, 32'd88, 32'd0, 0, 4'b1111, 2'd2, 1, 0, 0);
        step();
        n_cmp++; if (ex_input1 !== 32'd88 || ex_input2 !== 32'd88) begin n_bad++; $display("FAIL capture_operands got %0d/%0d want 88/88", ex_input1, ex_input2); end
        n_cmp++; if (ex_cmd !== 4'd15 || ex_alu_op !== 2'd2) begin n_bad++; $display("FAIL capture_cmd got %0d/%0d want 15/2", ex_cmd, ex_alu_op); end
        n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin n_bad++; $display("FAIL capture_ctrl got v%0d rd%0d rw%0d want v1 rd3 rw1", ex_valid, ex_rd, ex_reg_write); end
    endtask

    task automatic test_forward();
        set_id(1, 3, 4, 6, 32'd100, 32'd200, 32'd0, 0, 4'd1, 2'd0, 1, 0, 0);
        step();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'd7;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'd9;
        #1;
        n_cmp++; if (ex_input1 !== 32'd7) begin n_bad++; $display("FAIL fwd_exmem_priority got %0d want 7", ex_input1); end
        exmem_reg_write = 0; #1;
        n_cmp++; if (ex_input1 !== 32'd9) begin n_bad++; $display("FAIL fwd_memwb got %0d want 9", ex_input1); end
        memwb_reg_write = 0; #1;
        n_cmp++; if (ex_input1 !== 32'd100) begin n_bad++; $display("FAIL fwd_none got %0d want 100", ex_input1); end
        memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'd55; #1;
        n_cmp++; if (ex_input2 !== 32'd55 || ex_store_data !== 32'd55) begin n_bad++; $display("FAIL fwd_rt got %0d/%0d want 55/55", ex_input2, ex_store_data); end
        clear_fwd();
        set_id(1, 0, 0, 6, 32'd11, 32'd12, 32'd0, 0, 4'd1, 2'd0, 1, 0, 0);
        step();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'd7;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'd9; #1;
        n_cmp++; if (ex_input1 !== 32'd11 || ex_input2 !== 32'd12) begin n_bad++; $display("FAIL fwd_reg0 got %0d/%0d want 11/12", ex_input1, ex_input2); end
        clear_fwd();
    endtask

    task automatic test_load_use();
        set_id(1, 1, 0, 5, 32'd0, 32'd0, 32'd4, 1, 4'd2, 2'd0, 1, 1, 0);
        step();
        set_id(1, 5, 6, 7, 32'hDEAD, 32'd3, 32'd0, 0, 4'd2, 2'd2, 1, 0, 0);
        #1;
        n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %0d want 1", load_use_stall); end
        step();
        n_cmp++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got v%0d mr%0d lus%0d want 0 0 0", ex_valid, ex_mem_read, load_use_stall); end
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h1234;
        step();
        n_cmp++; if (ex_valid !== 1'b1 || ex_input1 !== 32'h1234 || ex_input2 !== 32'd3) begin n_bad++; $display("FAIL lu_after got v%0d in1 %0h in2 %0h want 1 1234 3", ex_valid, ex_input1, ex_input2); end
        clear_fwd();
    endtask

    task automatic test_immediate();
        set_id(1, 1, 0, 5, 32'd0, 32'd0, 32'd4, 1, 4'd2, 2'd0, 1, 1, 0);
        step();
        set_id(1, 2, 5, 8, 32'd21, 32'd99, 32'hFFFF_FFFC, 1, 4'd6, 2'd1, 1, 0, 0);
        #1;
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL imm_no_stall got %0d want 0", load_use_stall); end
        id_mem_write = 1; #1;
        n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL store_rt_stall got %0d want 1", load_use_stall); end
        flush_in = 1; #1;
        n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL flush_masks_stall got %0d want 0", load_use_stall); end
        flush_in = 0; id_mem_write = 0;
        step();
        n_cmp++; if (ex_valid !== 1'b1 || ex_input2 !== 32'hFFFF_FFFC || ex_store_data !== 32'd99) begin n_bad++; $display("FAIL imm_operand got v%0d in2 %0h sd %0h want 1 fffffffc 63", ex_valid, ex_input2, ex_store_data); end
    endtask

    task automatic test_flush_stall();
        set_id(1, 9, 10, 11, 32'd77, 32'd78, 32'd0, 0, 4'd3, 2'd3, 0, 0, 1);
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (ex_valid !== 1'b1 || ex_cmd !== 4'd6 || ex_input1 !== 32'd21 || ex_input2 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL stall_hold%0d got v%0d cmd%0d in1 %0d in2 %0h want 1 6 21 fffffffc", i, ex_valid, ex_cmd, ex_input1, ex_input2); end
        end
        flush_in = 1;
        step();
        n_cmp++; if (ex_valid !== 1'b0 || ex_cmd !== 4'd0 || ex_input1 !== 32'd0 || ex_input2 !== 32'd0 || ex_mem_write !== 1'b0 || load_use_stall !== 1'b0) begin n_bad++; $display("FAIL flush_bubble got v%0d cmd%0d in1 %0h in2 %0h mw%0d lus%0d want all 0", ex_valid, ex_cmd, ex_input1, ex_input2, ex_mem_write, load_use_stall); end
        flush_in = 0; stall_in = 0;
    endtask

    task automatic test_reset_mid_hazard();
        set_id(1, 1, 0, 5, 32'd0, 32'd0, 32'd4, 1, 4'd2, 2'd0, 1, 1, 0);
        step();
        set_id(1, 5, 6, 7, 32'd1, 32'd2, 32'd0, 0, 4'd2, 2'd2, 1, 0, 0);
        stall_in = 1; #1;
        n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL rst_hz_pre got %0d want 1", load_use_stall); end
        reset = 1;
        step();
        n_cmp++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== 5'd0 || load_use_stall !== 1'b0) begin n_bad++; $display("FAIL rst_hz_post got v%0d mr%0d rd%0d lus%0d want 0 0 0 0", ex_valid, ex_mem_read, ex_rd, load_use_stall); end
        reset = 0; stall_in = 0;
    endtask

    task automatic test_back_to_back();
        set_id(1, 12, 13, 14, 32'hA, 32'hB, 32'd0, 0, 4'd4, 2'd1, 1, 0, 0);
        step();
        n_cmp++; if (ex_input1 !== 32'hA || ex_rd !== 5'd14) begin n_bad++; $display("FAIL b2b_first got %0h rd%0d want a rd14", ex_input1, ex_rd); end
        set_id(1, 15, 16, 17, 32'hC, 32'hD, 32'h40, 1, 4'd5, 2'd2, 0, 0, 1);
        step();
        n_cmp++; if (ex_input1 !== 32'hC || ex_input2 !== 32'h40 || ex_store_data !== 32'hD || ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0) begin n_bad++; $display("FAIL b2b_second got %0h %0h %0h mw%0d rw%0d want c 40 d 1 0", ex_input1, ex_input2, ex_store_data, ex_mem_write, ex_reg_write); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forward();
        test_load_use();
        test_immediate();
        test_flush_stall();
        test_reset_mid_hazard();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_ex_forward_stage.md
Name: id_ex_forward_stage

Overview:
ID/EX pipeline stage that feeds the ALU.
- Registers decoded operands and control from decode.
- Resolves EX/MEM and MEM/WB forwarding, then drives the ALU operand and command inputs (input1, input2, ex_cmd, ALUOp).
- Detects load-use hazards and inserts a one-cycle bubble.
- Applies stall and flush requests from hazard/branch logic (branch resolved in decode).

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
stall_in  in  1  hold stage contents (downstream busy)
flush_in  in  1  replace next contents with bubble (taken branch)
id_valid  in  1  decode slot holds a real instruction
id_rs, id_rt, id_rd  in  REG_W  source/destination register numbers
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign/zero-extended immediate
id_alu_src  in  1  1 = input2 takes immediate
id_ex_cmd  in  4  ALU command
id_alu_op  in  2  ALU op class
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_W  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_W  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB result
ex_valid  out  1  EX slot valid
ex_input1, ex_input2  out  DATA_W  forwarded ALU operands
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_cmd  out  4  registered ALU command
ex_alu_op  out  2  registered ALU op class
ex_rd  out  REG_W  registered destination
ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered controls
load_use_stall  out  1  request decode/fetch hold

Behaviour:
- Reset:
  - All registered fields clear to 0.
  - Outputs settle to ex_valid=0, all controls 0, ex_input1/ex_input2/ex_store_data=0 (no forward matches reg 0).
  - load_use_stall=0.
- Bubble: valid, reg_write, mem_read, mem_write, cmd, alu_op, rd, rs, rt, data and imm all 0.
- Register update priority, per rising edge:
  - reset, then flush_in (load bubble), then stall_in (hold all).
  - Then load_use_stall (load bubble), then normal (capture id_* fields).
  - flush_in wins over stall_in.
- Load-use hazard (combinational):
  - load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | (ex_rd==id_rt & (!id_alu_src | id_mem_write))).
  - Forced 0 when flush_in=1.
  - Lasts exactly one cycle per load: the bubble clears ex_mem_read.
- Forwarding (combinational on registered rs/rt, applied per operand):
  - Use exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==reg.
  - Else use memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==reg.
  - Else use registered data.
  - EX/MEM has priority when both match. Register 0 is never forwarded.
- Operand selection:
  - ex_input1 = forwarded rs.
  - ex_input2 = imm if registered alu_src, else forwarded rt.
  - ex_store_data = forwarded rt, always.
- Forwarding ignores ex_valid. Bubbles carry rs=rt=0, so nothing matches.
- Latency: a decode instruction appears on the ex_* outputs 1 cycle after capture. Outputs track forward sources within the same cycle.
- Reset asserted mid-stall or mid-hazard: next cycle outputs the bubble and load_use_stall=0.

Test Plan:
1. Reset → after one edge: ex_valid=0, ex_reg_write=0, ex_cmd=0, ex_input1=0, load_use_stall=0.
2. Plain capture: id_rs_data=88, id_rt_data=88, id_ex_cmd=4'b1111, id_alu_op=2, id_alu_src=0 → next cycle ex_input1=88, ex_input2=88, ex_cmd=15, ex_alu_op=2, ex_valid=1.
3. Forward priority: registered rs=3, exmem_rd=3 result 7, memwb_rd=3 result 9 → ex_input1=7. Drop exmem_reg_write → 9. Set rs=0 with matching rd=0 → registered data, no forward.
4. Load-use: EX holds lw rd=5, decode add rs=5 → load_use_stall=1 for one cycle. Next cycle EX is bubble (ex_valid=0), stall=0. Add then captures and takes memwb forward.
5. Immediate: id_alu_src=1, imm=0xFFFFFFFC, rt=5 with EX load rd=5, id_mem_write=0 → no stall. ex_input2=0xFFFFFFFC.
6. Flush vs stall: stall_in=1 holds outputs for 3 cycles. Then flush_in=1 with stall_in=1 → bubble next cycle and load_use_stall=0.
